// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, protocol bit constants and byte width.
// Used by the target here and by the matching controller.
package i2c_pkg;
  localparam int   I2C_BYTE_W  = 8;
  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REG,
    WR_BYTE,
    RD_BYTE,
    WAIT_STOP,
    IGNORE
  } i2c_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA and produces edge and START/STOP pulses from the last two samples.
// Latency SYNC_STAGES+1 clk; no backpressure (pure sampling).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // SCL must be high in both samples, so a coincident SCL/SDA change is a data edge.
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
endmodule

// File: rtl/i2c_target.sv
// I2C register-pointer target: 16-bit write strobe and read-request strobe to local logic.
// Strobes fire on the SCL edge that completes the relevant byte; never stretches SCL.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  output logic [7:0]  reg_ptr,
  output logic [15:0] wr_data,
  output logic        wr_strobe,
  input  logic [15:0] rd_data,
  output logic        rd_strobe,
  output logic        busy
);
  logic sda_s, scl_rise, scl_fall, start_p, stop_p;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_p),
    .stop_o    (stop_p)
  );

  i2c_state_e              state_q, state_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0]   shift_q, shift_d, b0_q, b0_d, reg_ptr_q, reg_ptr_d;
  logic [I2C_BYTE_W-1:0]   rx_byte;
  logic [15:0]             tx_q, tx_d, wr_data_q, wr_data_d;
  logic                    byte_cnt_q, byte_cnt_d, rw_q, rw_d, ack_q, ack_d;
  logic                    sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic                    rd_strobe_q, rd_strobe_d, wr_strobe_q, wr_strobe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      b0_q        <= '0;
      reg_ptr_q   <= '0;
      tx_q        <= '0;
      wr_data_q   <= '0;
      byte_cnt_q  <= 1'b0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      b0_q        <= b0_d;
      reg_ptr_q   <= reg_ptr_d;
      tx_q        <= tx_d;
      wr_data_q   <= wr_data_d;
      byte_cnt_q  <= byte_cnt_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rd_strobe_q <= rd_strobe_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  assign rx_byte = {shift_q[I2C_BYTE_W-2:0], sda_s};

  // bit_cnt 0..7 are data bits, 8 is the ACK slot; the 9th rising edge wraps it to 0.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    b0_d        = b0_q;
    reg_ptr_d   = reg_ptr_q;
    tx_d        = tx_q;
    wr_data_d   = wr_data_q;
    byte_cnt_d  = byte_cnt_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rd_strobe_d = 1'b0;
    wr_strobe_d = 1'b0;

    if (rd_strobe_q) tx_d = rd_data;

    if (start_p) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = 1'b0;
      ack_d      = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (stop_p) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      ack_d     = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (state_q != IDLE) begin
      if (scl_rise) begin
        if (bit_cnt_q < 4'd8) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          bit_cnt_d = '0;
        end

        if (bit_cnt_q == 4'd7) begin
          case (state_q)
            ADDR: begin
              if (rx_byte[7:1] == ADDRESS) begin
                ack_d  = 1'b1;
                busy_d = 1'b1;
                rw_d   = rx_byte[0];
                if (rx_byte[0] == I2C_RW_READ) rd_strobe_d = 1'b1;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
            REG, WR_BYTE: ack_d = 1'b1;
            default: ;
          endcase
        end

        if (bit_cnt_q == 4'd8) begin
          ack_d = 1'b0;
          case (state_q)
            ADDR: begin
              state_d    = (rw_q == I2C_RW_READ) ? RD_BYTE : REG;
              byte_cnt_d = 1'b0;
            end
            REG: begin
              reg_ptr_d  = shift_q;
              state_d    = WR_BYTE;
              byte_cnt_d = 1'b0;
            end
            WR_BYTE: begin
              if (!byte_cnt_q) begin
                b0_d       = shift_q;
                byte_cnt_d = 1'b1;
              end else begin
                wr_data_d   = {b0_q, shift_q};
                wr_strobe_d = 1'b1;
                state_d     = WAIT_STOP;
              end
            end
            RD_BYTE: begin
              if (!byte_cnt_q) byte_cnt_d = 1'b1;
              else             state_d    = WAIT_STOP;
            end
            default: ;
          endcase
        end
      end else if (scl_fall) begin
        if (state_q == RD_BYTE && bit_cnt_q < 4'd8) begin
          sda_oe_d = ~tx_q[15];
          tx_d     = {tx_q[14:0], 1'b0};
        end else begin
          sda_oe_d = ack_q && (bit_cnt_q == 4'd8);
        end
      end
    end
  end

  assign sda       = sda_oe_q ? I2C_ACK : 1'bz;
  assign reg_ptr   = reg_ptr_q;
  assign wr_data   = wr_data_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C controller driving i2c_target through directed frames and corner cases.
module tb_i2c_target;
  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_low;
  logic [15:0] rd_data;
  wire         sda;
  logic [7:0]  reg_ptr;
  logic [15:0] wr_data;
  logic        wr_strobe, rd_strobe, busy;

  i2c_target #(.ADDRESS(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .reg_ptr  (reg_ptr),
    .wr_data  (wr_data),
    .wr_strobe(wr_strobe),
    .rd_data  (rd_data),
    .rd_strobe(rd_strobe),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  localparam int Q = 8;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, low_cnt = 0;

  always @(negedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (rd_strobe) rd_cnt++;
    if (busy) busy_cnt++;
    if (!sda_low && sda === 1'b0) low_cnt++;
  end

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  ptr;
    logic [15:0] val;
    int          exp_acks;
    int          exp_wr;
    int          exp_rd;
    logic [7:0]  exp_ptr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_dout;
    logic        exp_busy;
    logic        exp_low;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic wbit(input logic b);
    sda_low = ~b; qwait();
    scl = 1'b1;   qwait(); qwait();
    scl = 1'b0;   qwait();
  endtask

  task automatic rbit(output logic b);
    sda_low = 1'b0; qwait();
    scl = 1'b1;     qwait();
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    qwait();
    scl = 1'b0;     qwait();
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    rbit(b);
    ack = (b == 1'b0);
  endtask

  task automatic rbyte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      v[i] = b;
    end
    wbit(nack);
  endtask

  task automatic start_c();
    sda_low = 1'b0; qwait();
    scl = 1'b1;     qwait();
    sda_low = 1'b1; qwait();
    scl = 1'b0;     qwait();
  endtask

  task automatic stop_c();
    sda_low = 1'b1; qwait();
    scl = 1'b1;     qwait();
    sda_low = 1'b0; qwait(); qwait();
  endtask

  task automatic run_frame(input vec_t v, output int acks, output logic [15:0] dout);
    logic       a;
    logic [7:0] hi, lo;
    acks = 0;
    dout = '0;
    rd_data = v.val;
    start_c();
    wbyte({v.addr, 1'b0}, a); acks += int'(a);
    wbyte(v.ptr, a);          acks += int'(a);
    if (!v.rw) begin
      wbyte(v.val[15:8], a);  acks += int'(a);
      wbyte(v.val[7:0], a);   acks += int'(a);
      stop_c();
    end else begin
      stop_c();
      start_c();
      wbyte({v.addr, 1'b1}, a); acks += int'(a);
      rbyte(hi, 1'b0);
      rbyte(lo, 1'b1);
      dout = {hi, lo};
      stop_c();
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int          acks, wr0, rd0, busy0, low0;
    logic [15:0] dout;
    wr0 = wr_cnt; rd0 = rd_cnt; busy0 = busy_cnt; low0 = low_cnt;
    run_frame(v, acks, dout);
    chk({tag, "_acks"},    acks, v.exp_acks);
    chk({tag, "_wr_cnt"},  wr_cnt - wr0, v.exp_wr);
    chk({tag, "_rd_cnt"},  rd_cnt - rd0, v.exp_rd);
    chk({tag, "_reg_ptr"}, reg_ptr, v.exp_ptr);
    chk({tag, "_wr_data"}, wr_data, v.exp_wdata);
    chk({tag, "_dout"},    dout, v.exp_dout);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_busy_seen"}, (busy_cnt - busy0) > 0, v.exp_busy);
    chk({tag, "_tgt_low"}, (low_cnt - low0) > 0, v.exp_low);
  endtask

  initial begin
    logic        a;
    int          acks, wr0, rd0;
    logic [7:0]  hi, lo;
    logic [7:0]  abyte;
    vec_t        v;

    //         rw  addr   ptr    val       acks wr rd ptr    wdata     dout      busy low
    vecs[0] = '{1'b0, 7'h50, 8'h12, 16'hBEEF, 4, 1, 0, 8'h12, 16'hBEEF, 16'h0000, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 7'h50, 8'h34, 16'hCAFE, 3, 0, 1, 8'h34, 16'hBEEF, 16'hCAFE, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 7'h51, 8'h77, 16'h1234, 0, 0, 0, 8'h34, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 7'h50, 8'hA5, 16'h0001, 4, 1, 0, 8'hA5, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 7'h50, 8'hA5, 16'h807F, 3, 0, 1, 8'hA5, 16'h0001, 16'h807F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 7'h51, 8'h00, 16'h5555, 0, 0, 0, 8'hA5, 16'h0001, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b1; scl = 1'b1; sda_low = 1'b0; rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_ptr", reg_ptr, 8'h00);
    chk("rst_wr_data", wr_data, 16'h0000);
    chk("rst_strobes", {wr_strobe, rd_strobe}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda_released", sda, 1'b1);
    rst = 1'b0;
    qwait();

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // STOP after 4 bits of the data MSB byte: aborted frame must not strobe.
    wr0 = wr_cnt;
    start_c();
    wbyte(8'hA0, a);
    wbyte(8'h22, a);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    stop_c();
    chk("abort_wr_cnt", wr_cnt - wr0, 0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_reg_ptr", reg_ptr, 8'h22);
    v = '{1'b0, 7'h50, 8'h01, 16'h0102, 4, 1, 0, 8'h01, 16'h0102, 16'h0000, 1'b1, 1'b1};
    apply_vec(v, "after_abort");

    // Reset while the target holds the address ACK low.
    abyte = 8'hA0;
    start_c();
    for (int i = 7; i >= 0; i--) wbit(abyte[i]);
    sda_low = 1'b0; qwait();
    scl = 1'b1;     qwait();
    chk("rstack_driven", sda, 1'b0);
    chk("rstack_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstack_sda_released", sda, 1'b1);
    chk("rstack_busy", busy, 1'b0);
    chk("rstack_reg_ptr", reg_ptr, 8'h00);
    chk("rstack_wr_data", wr_data, 16'h0000);
    scl = 1'b0; qwait();
    rst = 1'b0; qwait();
    v = '{1'b0, 7'h50, 8'h5A, 16'h55AA, 4, 1, 0, 8'h5A, 16'h55AA, 16'h0000, 1'b1, 1'b1};
    apply_vec(v, "after_rst");

    // Repeated START straight after the pointer byte, then addr+R.
    wr0 = wr_cnt; rd0 = rd_cnt; acks = 0;
    rd_data = 16'h1357;
    start_c();
    wbyte(8'hA0, a); acks += int'(a);
    wbyte(8'h66, a); acks += int'(a);
    start_c();
    wbyte(8'hA1, a); acks += int'(a);
    rbyte(hi, 1'b0);
    rbyte(lo, 1'b1);
    stop_c();
    chk("rs_acks", acks, 3);
    chk("rs_reg_ptr", reg_ptr, 8'h66);
    chk("rs_dout", {hi, lo}, 16'h1357);
    chk("rs_rd_cnt", rd_cnt - rd0, 1);
    chk("rs_wr_cnt", wr_cnt - wr0, 0);
    chk("rs_busy_end", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
